hdmi_receiver: RTL and testbench

HDMI_RECEIVER -- requirements
Module: hdmi_receiver

---
 rtl/hdmi_receiver_if.sv | 33 +++
 rtl/hdmi_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_hdmi_receiver.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_receiver_if.sv
// Bundle of the TMDS word inputs and recovered video / frame-buffer outputs of hdmi_receiver.
// The receiver uses the slave side; the TMDS source and frame-buffer sink use the master side.
interface hdmi_receiver_if;
  logic [9:0]  tmds_red;
  logic [9:0]  tmds_green;
  logic [9:0]  tmds_blue;
  logic        bitslip;
  logic        locked;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [25:0] ram_addr;
  logic [7:0]  ram_red;
  logic [7:0]  ram_green;
  logic [7:0]  ram_blue;
  logic        ram_we;
  logic        frame_start;
  logic        decode_err;

  modport slave (
    input  tmds_red, tmds_green, tmds_blue,
    output bitslip, locked, hsync, vsync, de,
    output ram_addr, ram_red, ram_green, ram_blue, ram_we,
    output frame_start, decode_err
  );

  modport master (
    output tmds_red, tmds_green, tmds_blue,
    input  bitslip, locked, hsync, vsync, de,
    input  ram_addr, ram_red, ram_green, ram_blue, ram_we,
    input  frame_start, decode_err
  );
endinterface

// File: rtl/hdmi_receiver.sv
// TMDS receiver: word alignment via bitslip, control/data decode, sync recovery and
// frame-buffer write generation with a two-stage pipeline.
module hdmi_receiver #(
  parameter int unsigned h_pixel       = 640,
  parameter int unsigned v_pixel       = 480,
  parameter int unsigned align_timeout = 1024,
  parameter int unsigned slip_wait     = 16,
  parameter int unsigned ctrl_run      = 8,
  parameter int unsigned lock_loss     = 2048
) (
  input logic        clk_low,
  input logic        reset,
  hdmi_receiver_if.slave bus
);

  localparam int unsigned MAX_AS  = (align_timeout > slip_wait) ? align_timeout : slip_wait;
  localparam int unsigned CNT_MAX = (MAX_AS > lock_loss) ? MAX_AS : lock_loss;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RUN_W   = $clog2(ctrl_run + 1);
  localparam logic [25:0] ADDR_LAST = 26'(h_pixel * v_pixel - 1);

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } state_t;

  function automatic logic is_ctrl(input logic [9:0] q);
    logic r;
    case (q)
      10'b1101010100,
      10'b0010101011,
      10'b0101010100,
      10'b1010101011: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ctrl_bits(input logic [9:0] q);
    logic [1:0] c;
    case (q)
      10'b0010101011: c = 2'b01;
      10'b0101010100: c = 2'b10;
      10'b1010101011: c = 2'b11;
      default:        c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] p;
    logic [7:0] d;
    p    = q[9] ? ~q[7:0] : q[7:0];
    d    = '0;
    d[0] = p[0];
    for (int unsigned i = 1; i < 8; i++) begin
      d[i] = q[8] ? (p[i] ^ p[i-1]) : ~(p[i] ^ p[i-1]);
    end
    return d;
  endfunction

  logic       blue_ctrl, red_ctrl, green_ctrl;
  logic [1:0] blue_c;

  assign blue_ctrl  = is_ctrl(bus.tmds_blue);
  assign red_ctrl   = is_ctrl(bus.tmds_red);
  assign green_ctrl = is_ctrl(bus.tmds_green);
  assign blue_c     = ctrl_bits(bus.tmds_blue);

  // Alignment FSM; one shared counter serves as timeout, settle and lock-loss timer.
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [RUN_W-1:0]   run, run_n, run_inc;
  logic               slip_n;
  logic               bitslip_q;

  assign cnt_inc = cnt + CNT_W'(1);
  assign run_inc = run + RUN_W'(1);

  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      cnt       <= '0;
      run       <= '0;
      bitslip_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      run       <= run_n;
      bitslip_q <= slip_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    run_n   = '0;
    slip_n  = 1'b0;
    case (state)
      SEARCH: begin
        run_n = blue_ctrl ? run_inc : '0;
        if (blue_ctrl && (run_inc == RUN_W'(ctrl_run))) begin
          state_n = LOCKED;
          cnt_n   = '0;
          run_n   = '0;
        end else if (cnt_inc == CNT_W'(align_timeout)) begin
          state_n = SLIP;
          cnt_n   = '0;
          run_n   = '0;
          slip_n  = 1'b1;
        end
      end
      SLIP: begin
        if (cnt_inc == CNT_W'(slip_wait)) begin
          state_n = SEARCH;
          cnt_n   = '0;
        end
      end
      LOCKED: begin
        if (blue_ctrl) begin
          cnt_n = '0;
        end else if (cnt_inc == CNT_W'(lock_loss)) begin
          state_n = SEARCH;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = SEARCH;
        cnt_n   = '0;
      end
    endcase
  end

  // Stage 1: decoded word plus the lock context it arrived in.
  logic [7:0] d1_red, d1_green, d1_blue;
  logic       de1, lk1, hs1, vs1, err1;
  logic       is_locked;

  assign is_locked = (state == LOCKED);

  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      d1_red   <= '0;
      d1_green <= '0;
      d1_blue  <= '0;
      de1      <= 1'b0;
      lk1      <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      err1     <= 1'b0;
    end else begin
      d1_red   <= decode(bus.tmds_red);
      d1_green <= decode(bus.tmds_green);
      d1_blue  <= decode(bus.tmds_blue);
      de1      <= is_locked && !blue_ctrl;
      lk1      <= is_locked;
      if (blue_ctrl) begin
        hs1 <= blue_c[0];
        vs1 <= blue_c[1];
      end
      err1 <= is_locked && ((blue_ctrl != red_ctrl) || (blue_ctrl != green_ctrl));
    end
  end

  // Stage 2: registered outputs and frame-buffer addressing.
  logic [7:0]  ram_red_q, ram_green_q, ram_blue_q;
  logic [25:0] addr_q;
  logic        we_q, hsync_q, vsync_q, fs_q, err_q;
  logic        frame_rise;

  // vs1 is the value stage-2 vsync takes at this edge, so this marks its rising edge.
  assign frame_rise = lk1 && vs1 && !vsync_q;

  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      ram_red_q   <= '0;
      ram_green_q <= '0;
      ram_blue_q  <= '0;
      we_q        <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      ram_red_q   <= d1_red;
      ram_green_q <= d1_green;
      ram_blue_q  <= d1_blue;
      we_q        <= de1;
      hsync_q     <= hs1;
      vsync_q     <= vs1;
      fs_q        <= frame_rise;
      err_q       <= err1;
      if (frame_rise) begin
        addr_q <= '0;
      end else if (we_q) begin
        addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 26'd1;
      end
    end
  end

  assign bus.bitslip     = bitslip_q;
  assign bus.locked      = is_locked;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = we_q;
  assign bus.ram_we      = we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_red     = ram_red_q;
  assign bus.ram_green   = ram_green_q;
  assign bus.ram_blue    = ram_blue_q;
  assign bus.frame_start = fs_q;
  assign bus.decode_err  = err_q;

endmodule

// File: tb/tb_hdmi_receiver.sv
// Self-checking bench for hdmi_receiver: directed phases with random TMDS words,
// checked every cycle against a word-by-word behavioural model.
module tb_hdmi_receiver;
  localparam int unsigned HP    = 8;
  localparam int unsigned VP    = 4;
  localparam int unsigned FRAME = HP * VP;
  localparam int unsigned ATO   = 1024;
  localparam int unsigned SW    = 16;
  localparam int unsigned CR    = 8;
  localparam int unsigned LL    = 2048;

  localparam int M_SEARCH = 0;
  localparam int M_SLIP   = 1;
  localparam int M_LOCKED = 2;

  logic clk_low = 1'b0;
  logic reset;

  hdmi_receiver_if bus();

  hdmi_receiver #(
    .h_pixel(HP),
    .v_pixel(VP),
    .align_timeout(ATO),
    .slip_wait(SW),
    .ctrl_run(CR),
    .lock_loss(LL)
  ) dut (
    .clk_low(clk_low),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_low = ~clk_low;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  // Index of each token equals its control code C.
  logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  typedef struct {
    bit       we;
    bit       lk;
    bit       hs;
    bit       vs;
    bit       err;
    bit [7:0] r;
    bit [7:0] g;
    bit [7:0] b;
  } rec_t;

  rec_t     pend, shown;
  int       mode, run_len, elapsed, quiet;
  bit       last_hs, last_vs, slip_exp, fs_exp;
  bit [25:0] addr_exp;

  function automatic int tok_index(input logic [9:0] q);
    for (int i = 0; i < 4; i++) if (tokens[i] == q) return i;
    return -1;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] q);
    logic [7:0] p, x;
    p = q[9] ? ~q[7:0] : q[7:0];
    x = p ^ (p << 1);
    if (!q[8]) x = x ^ 8'hFE;
    return x;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] q;
    do q = 10'($urandom_range(0, 1023)); while (tok_index(q) >= 0);
    return q;
  endfunction

  function automatic logic [9:0] rand_word(input int ctrl_pct);
    if (int'($urandom_range(0, 99)) < ctrl_pct) return tokens[$urandom_range(0, 3)];
    return rand_data();
  endfunction

  task automatic model_reset();
    pend     = '{default: 0};
    shown    = '{default: 0};
    mode     = M_SEARCH;
    run_len  = 0;
    elapsed  = 0;
    quiet    = 0;
    last_hs  = 0;
    last_vs  = 0;
    slip_exp = 0;
    fs_exp   = 0;
    addr_exp = '0;
  endtask

  task automatic model_edge(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    rec_t w;
    bit   was_locked, prev_we, prev_vs, bc, rc, gc;
    int   bi;
    was_locked = (mode == M_LOCKED);
    bi = tok_index(b);
    bc = (bi >= 0);
    rc = (tok_index(r) >= 0);
    gc = (tok_index(g) >= 0);
    if (bc) begin
      last_hs = bi[0];
      last_vs = bi[1];
    end
    w.lk  = was_locked;
    w.we  = was_locked && !bc;
    w.hs  = last_hs;
    w.vs  = last_vs;
    w.err = was_locked && ((bc != rc) || (bc != gc));
    w.r   = tmds_dec(r);
    w.g   = tmds_dec(g);
    w.b   = tmds_dec(b);

    prev_we = shown.we;
    prev_vs = shown.vs;
    shown   = pend;
    pend    = w;
    fs_exp  = shown.lk && shown.vs && !prev_vs;
    if (fs_exp) addr_exp = '0;
    else if (prev_we) addr_exp = 26'((int'(addr_exp) + 1) % FRAME);

    slip_exp = 0;
    if (mode == M_SEARCH) begin
      elapsed++;
      run_len = bc ? run_len + 1 : 0;
      if (run_len == CR) begin
        mode = M_LOCKED; quiet = 0; run_len = 0; elapsed = 0;
      end else if (elapsed == ATO) begin
        mode = M_SLIP; slip_exp = 1; elapsed = 0; run_len = 0;
      end
    end else if (mode == M_SLIP) begin
      elapsed++;
      if (elapsed == SW) begin
        mode = M_SEARCH; elapsed = 0; run_len = 0;
      end
    end else begin
      quiet = bc ? 0 : quiet + 1;
      if (quiet == LL) begin
        mode = M_SEARCH; elapsed = 0; run_len = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("locked",      32'(bus.locked),      32'(mode == M_LOCKED));
    chk("bitslip",     32'(bus.bitslip),     32'(slip_exp));
    chk("de",          32'(bus.de),          32'(shown.we));
    chk("ram_we",      32'(bus.ram_we),      32'(shown.we));
    chk("hsync",       32'(bus.hsync),       32'(shown.hs));
    chk("vsync",       32'(bus.vsync),       32'(shown.vs));
    chk("frame_start", 32'(bus.frame_start), 32'(fs_exp));
    chk("decode_err",  32'(bus.decode_err),  32'(shown.err));
    chk("ram_addr",    32'(bus.ram_addr),    32'(addr_exp));
    if (shown.we) begin
      chk("ram_red",   32'(bus.ram_red),     32'(shown.r));
      chk("ram_green", 32'(bus.ram_green),   32'(shown.g));
      chk("ram_blue",  32'(bus.ram_blue),    32'(shown.b));
    end
  endtask

  task automatic step(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    bus.tmds_red   = r;
    bus.tmds_green = g;
    bus.tmds_blue  = b;
    @(posedge clk_low);
    #1;
    model_edge(r, g, b);
    check_all();
  endtask

  initial begin
    reset          = 1'b1;
    bus.tmds_red   = '0;
    bus.tmds_green = '0;
    bus.tmds_blue  = '0;
    model_reset();
    #12;
    check_all();
    reset = 1'b0;

    // Lock on a run of C=00 control tokens.
    repeat (CR) step(tokens[0], tokens[0], tokens[0]);

    // Random pixels; enough writes to wrap the frame buffer address.
    repeat (FRAME + 8) step(rand_data(), rand_data(), rand_data());

    // hsync pulse then vsync rise: frame start and address clear.
    repeat (2) step(tokens[0], tokens[0], tokens[1]);
    repeat (3) step(tokens[0], tokens[0], tokens[2]);
    repeat (2) step(tokens[0], tokens[0], tokens[0]);

    // Directed decode words.
    step(10'b0100000000, 10'b0100000000, 10'b0100000000);
    step(10'b1111111111, 10'b1111111111, 10'b1111111111);
    repeat (20) step(rand_data(), rand_data(), rand_data());

    // Mixed control/data per channel, including decode errors and random syncs.
    repeat (300) step(rand_word(30), rand_word(30), rand_word(30));

    // No blue control: lock loss, then search timeout, bitslip and settle.
    repeat (LL + ATO + SW + 50) step(rand_data(), rand_data(), rand_data());

    // Relock with C=11 and stream some pixels.
    repeat (CR) step(tokens[3], tokens[3], tokens[3]);
    repeat (10) step(rand_data(), rand_data(), rand_data());

    // Asynchronous reset mid-frame.
    bus.tmds_blue = rand_data();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (3) @(posedge clk_low);
    #1;
    check_all();
    reset = 1'b0;

    repeat (CR) step(tokens[0], tokens[0], tokens[0]);
    repeat (60) step(rand_word(20), rand_word(20), rand_word(20));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
